// File: rtl/pg_pkg.sv
// Shared constants for the pulse generator: state encoding, microsecond counter
// width and helpers that size the clock-to-microsecond prescaler.
package pg_pkg;

  localparam int US_WIDTH = 24;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RUNNING = 2'd2;

  function automatic int pg_us_div(input int clk_freq_hz);
    return clk_freq_hz / 1_000_000;
  endfunction

  // Never narrower than one bit so a divide-by-2 prescaler still has a register.
  function automatic int pg_presc_width(input int us_div);
    if (us_div <= 2) return 1;
    return $clog2(us_div);
  endfunction

endpackage

// File: rtl/pulse_generator_core_if.sv
// Register-file, wall-time and status bundle of one pulse generator.
// master = register file / timebase side, slave = pulse_generator_core.
interface pulse_generator_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_pps;
  logic [15:0]           i_year;
  logic [DATA_WIDTH-1:0] i_month;
  logic [DATA_WIDTH-1:0] i_day;
  logic [DATA_WIDTH-1:0] i_hour;
  logic [DATA_WIDTH-1:0] i_minutes;
  logic [DATA_WIDTH-1:0] i_seconds;
  logic [DATA_WIDTH-1:0] i_pulse_enable;
  logic [DATA_WIDTH-1:0] i_usr_year_h;
  logic [DATA_WIDTH-1:0] i_usr_year_l;
  logic [DATA_WIDTH-1:0] i_usr_month;
  logic [DATA_WIDTH-1:0] i_usr_day;
  logic [DATA_WIDTH-1:0] i_usr_hour;
  logic [DATA_WIDTH-1:0] i_usr_minutes;
  logic [DATA_WIDTH-1:0] i_usr_seconds;
  logic [DATA_WIDTH-1:0] i_width_high_2;
  logic [DATA_WIDTH-1:0] i_width_high_1;
  logic [DATA_WIDTH-1:0] i_width_high_0;
  logic [DATA_WIDTH-1:0] i_width_period_2;
  logic [DATA_WIDTH-1:0] i_width_period_1;
  logic [DATA_WIDTH-1:0] i_width_period_0;
  logic                  o_pulse;
  logic                  o_armed;
  logic                  o_running;
  logic                  o_cfg_err;
  logic [1:0]            o_state;

  // Level-based register fields, no handshake: the core samples them every
  // cycle and only i_pps is a single-cycle strobe.
  modport master (
    output i_pps, i_year, i_month, i_day, i_hour, i_minutes, i_seconds,
    output i_pulse_enable, i_usr_year_h, i_usr_year_l, i_usr_month, i_usr_day,
    output i_usr_hour, i_usr_minutes, i_usr_seconds,
    output i_width_high_2, i_width_high_1, i_width_high_0,
    output i_width_period_2, i_width_period_1, i_width_period_0,
    input  o_pulse, o_armed, o_running, o_cfg_err, o_state
  );

  modport slave (
    input  i_pps, i_year, i_month, i_day, i_hour, i_minutes, i_seconds,
    input  i_pulse_enable, i_usr_year_h, i_usr_year_l, i_usr_month, i_usr_day,
    input  i_usr_hour, i_usr_minutes, i_usr_seconds,
    input  i_width_high_2, i_width_high_1, i_width_high_0,
    input  i_width_period_2, i_width_period_1, i_width_period_0,
    output o_pulse, o_armed, o_running, o_cfg_err, o_state
  );

endinterface

// File: rtl/pg_us_prescaler.sv
// Divides the system clock down to a one-cycle tick per microsecond.
// Synchronous clear has priority over enable; the tick is suppressed while clearing.
module pg_us_prescaler
  import pg_pkg::*;
#(
  parameter int US_DIV = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = pg_presc_width(US_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terminal;

  assign terminal = (cnt_q == CW'(US_DIV - 1));
  assign tick_o   = en_i & ~clr_i & terminal;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = terminal ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_generator_core.sv
// One pulse-train generator: arms on enable, starts on the PPS of the user start time,
// then emits WIDTH_HIGH us high every WIDTH_PERIOD us. Optional PG_RELOAD_EN macro.
module pulse_generator_core
  import pg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  pulse_generator_core_if.slave pg
);

  localparam int US_DIV = pg_us_div(CLK_FREQ_HZ);

  logic [1:0]          state_q, state_d;
  logic                cfg_err_q, cfg_err_d;
  logic                pulse_q, pulse_d;
  logic [US_WIDTH-1:0] width_sh_q, width_sh_d;
  logic [US_WIDTH-1:0] period_sh_q, period_sh_d;
  logic [US_WIDTH-1:0] us_cnt_q, us_cnt_d;

  logic                enable;
  logic [US_WIDTH-1:0] width_in;
  logic [US_WIDTH-1:0] period_in;
  logic [15:0]         usr_year;
  logic                time_match;
  logic                running;
  logic                us_tick;
  logic                wrap;

  assign enable    = pg.i_pulse_enable[0];
  assign width_in  = US_WIDTH'({pg.i_width_high_2, pg.i_width_high_1, pg.i_width_high_0});
  assign period_in = US_WIDTH'({pg.i_width_period_2, pg.i_width_period_1, pg.i_width_period_0});
  assign usr_year  = 16'({pg.i_usr_year_h, pg.i_usr_year_l});
  assign running   = (state_q == ST_RUNNING);

  assign time_match = (pg.i_year    == usr_year)          &&
                      (pg.i_month   == pg.i_usr_month)    &&
                      (pg.i_day     == pg.i_usr_day)      &&
                      (pg.i_hour    == pg.i_usr_hour)     &&
                      (pg.i_minutes == pg.i_usr_minutes)  &&
                      (pg.i_seconds == pg.i_usr_seconds);

  // Held in clear outside RUNNING so the first microsecond after start is a full one.
  pg_us_prescaler #(
    .US_DIV (US_DIV)
  ) u_prescaler (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .clr_i  (~running),
    .en_i   (running),
    .tick_o (us_tick)
  );

  assign wrap = us_tick && (us_cnt_q == period_sh_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    cfg_err_d   = 1'b0;
    width_sh_d  = width_sh_q;
    period_sh_d = period_sh_q;
    us_cnt_d    = us_cnt_q;
    if (!enable) begin
      state_d  = ST_IDLE;
      us_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          us_cnt_d = '0;
          if (period_in == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          us_cnt_d = '0;
          if (period_in == '0) begin
            state_d   = ST_IDLE;
            cfg_err_d = 1'b1;
          end else if (pg.i_pps && time_match) begin
            state_d     = ST_RUNNING;
            width_sh_d  = width_in;
            period_sh_d = period_in;
          end
        end
        ST_RUNNING: begin
          if (wrap) begin
            us_cnt_d = '0;
`ifdef PG_RELOAD_EN
            width_sh_d  = width_in;
            period_sh_d = period_in;
            if (period_in == '0) begin
              state_d   = ST_IDLE;
              cfg_err_d = 1'b1;
            end
`endif
          end else if (us_tick) begin
            us_cnt_d = us_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          us_cnt_d = '0;
        end
      endcase
    end
    // Computed from next-state values so the pulse edge lands on the start edge itself.
    pulse_d = (state_d == ST_RUNNING) && (us_cnt_d < width_sh_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cfg_err_q   <= 1'b0;
      pulse_q     <= 1'b0;
      width_sh_q  <= '0;
      period_sh_q <= '0;
      us_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cfg_err_q   <= cfg_err_d;
      pulse_q     <= pulse_d;
      width_sh_q  <= width_sh_d;
      period_sh_q <= period_sh_d;
      us_cnt_q    <= us_cnt_d;
    end
  end

  assign pg.o_pulse   = pulse_q;
  assign pg.o_armed   = (state_q == ST_ARMED);
  assign pg.o_running = running;
  assign pg.o_cfg_err = cfg_err_q;
  assign pg.o_state   = state_q;

endmodule

// File: tb/tb_pulse_generator_core.sv
// Directed bench for pulse_generator_core at 10 MHz (10 clocks per microsecond).
// Expectations for the mid-run period write follow the PG_RELOAD_EN build option.
module tb_pulse_generator_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pulse_generator_core_if #(.DATA_WIDTH(8)) pg_if ();

  pulse_generator_core #(
    .CLK_FREQ_HZ (10_000_000),
    .DATA_WIDTH  (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .pg      (pg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic p, input logic a,
                            input logic r, input logic e);
    check({tag, ".pulse"},   32'(pg_if.o_pulse),   32'(p));
    check({tag, ".armed"},   32'(pg_if.o_armed),   32'(a));
    check({tag, ".running"}, 32'(pg_if.o_running), 32'(r));
    check({tag, ".cfg_err"}, 32'(pg_if.o_cfg_err), 32'(e));
  endtask

  task automatic set_cfg(input logic [23:0] width, input logic [23:0] period);
    pg_if.i_width_high_2   = width[23:16];
    pg_if.i_width_high_1   = width[15:8];
    pg_if.i_width_high_0   = width[7:0];
    pg_if.i_width_period_2 = period[23:16];
    pg_if.i_width_period_1 = period[15:8];
    pg_if.i_width_period_0 = period[7:0];
  endtask

  task automatic set_time(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                          input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    pg_if.i_year    = y;
    pg_if.i_month   = mo;
    pg_if.i_day     = d;
    pg_if.i_hour    = h;
    pg_if.i_minutes = mi;
    pg_if.i_seconds = s;
  endtask

  // One-cycle PPS strobe; returns at start edge + #1.
  task automatic pps_pulse();
    pg_if.i_pps = 1'b1;
    step(1);
    pg_if.i_pps = 1'b0;
  endtask

  task automatic set_enable(input logic en);
    pg_if.i_pulse_enable = {7'b1010101, en};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    pg_if.i_pps = 1'b0;
    set_enable(1'b0);
    set_time(16'd2024, 8'd5, 8'd17, 8'd12, 8'd29, 8'd59);
    pg_if.i_usr_year_h  = 8'h07;
    pg_if.i_usr_year_l  = 8'hE8;
    pg_if.i_usr_month   = 8'd5;
    pg_if.i_usr_day     = 8'd17;
    pg_if.i_usr_hour    = 8'd12;
    pg_if.i_usr_minutes = 8'd30;
    pg_if.i_usr_seconds = 8'd0;
    set_cfg(24'd10, 24'd100);
    step(3);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.state", 32'(pg_if.o_state), 32'd0);
    rst_n = 1'b1;
    step(2);
    check_outs("idle_disabled", 1'b0, 1'b0, 1'b0, 1'b0);

    // Arm, then a PPS one second late must not start the train.
    set_enable(1'b1);
    step(1);
    check_outs("armed", 1'b0, 1'b1, 1'b0, 1'b0);
    check("armed.state", 32'(pg_if.o_state), 32'd1);
    set_time(16'd2024, 8'd5, 8'd17, 8'd12, 8'd30, 8'd1);
    pps_pulse();
    step(5);
    check_outs("no_match", 1'b0, 1'b1, 1'b0, 1'b0);

    // Matching PPS: start edge N+1, high 100 clk, period 1000 clk.
    set_time(16'd2024, 8'd5, 8'd17, 8'd12, 8'd30, 8'd0);
    pps_pulse();
    check_outs("start", 1'b1, 1'b0, 1'b1, 1'b0);
    check("start.state", 32'(pg_if.o_state), 32'd2);
    step(99);
    check("high_last", 32'(pg_if.o_pulse), 32'd1);
    step(1);
    check("high_end", 32'(pg_if.o_pulse), 32'd0);
    pps_pulse();
    check("pps_ignored", 32'(pg_if.o_pulse), 32'd0);
    step(898);
    check("low_last", 32'(pg_if.o_pulse), 32'd0);
    step(1);
    check_outs("period_wrap", 1'b1, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while the pulse is high.
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    set_enable(1'b0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("reset_release.state", 32'(pg_if.o_state), 32'd0);

    // Zero period: error flag, never armed; a legal period arms next cycle.
    set_cfg(24'd10, 24'd0);
    set_enable(1'b1);
    step(1);
    check_outs("cfg_err", 1'b0, 1'b0, 1'b0, 1'b1);
    step(3);
    check("cfg_err_hold.state", 32'(pg_if.o_state), 32'd0);
    set_cfg(24'd10, 24'd50);
    step(1);
    check_outs("cfg_fixed", 1'b0, 1'b1, 1'b0, 1'b0);

    // Width beyond period: constantly high.
    set_enable(1'b0);
    step(1);
    set_cfg(24'd200, 24'd100);
    set_enable(1'b1);
    step(1);
    pps_pulse();
    check_outs("wide_start", 1'b1, 1'b0, 1'b1, 1'b0);
    step(500);
    check("wide_mid", 32'(pg_if.o_pulse), 32'd1);
    step(1000);
    check("wide_after_wrap", 32'(pg_if.o_pulse), 32'd1);

    // Disable drops the pulse on the next edge and returns to IDLE.
    set_enable(1'b0);
    step(1);
    check_outs("disable", 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero width: running but never high.
    set_cfg(24'd0, 24'd100);
    set_enable(1'b1);
    step(1);
    pps_pulse();
    check_outs("zero_width", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1500);
    check_outs("zero_width_later", 1'b0, 1'b0, 1'b1, 1'b0);

    // Period rewritten to 200 us while running.
    set_enable(1'b0);
    step(1);
    set_cfg(24'd10, 24'd100);
    set_enable(1'b1);
    step(1);
    pps_pulse();
    check("live_start", 32'(pg_if.o_pulse), 32'd1);
    set_cfg(24'd10, 24'd200);
    step(999);
    check("live_old_low", 32'(pg_if.o_pulse), 32'd0);
    step(1);
    check("live_first_wrap", 32'(pg_if.o_pulse), 32'd1);
    step(1000);
`ifdef PG_RELOAD_EN
    check("reload_new_period", 32'(pg_if.o_pulse), 32'd0);
    step(1000);
    check("reload_second_wrap", 32'(pg_if.o_pulse), 32'd1);
`else
    check("no_reload_old_period", 32'(pg_if.o_pulse), 32'd1);
    set_enable(1'b0);
    step(1);
    check_outs("rearm_off", 1'b0, 1'b0, 1'b0, 1'b0);
    set_enable(1'b1);
    step(1);
    pps_pulse();
    check("rearm_start", 32'(pg_if.o_pulse), 32'd1);
    step(1000);
    check("rearm_new_period", 32'(pg_if.o_pulse), 32'd0);
    step(1000);
    check("rearm_wrap", 32'(pg_if.o_pulse), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
